// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: accepts a DIGITS-digit word, folds one
// digit per clock MSD-first (acc = acc*10 + digit), and hands the result out on a handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int IN_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IN_W-1:0]    shift_reg, shift_next;
  logic [BIN_W-1:0]   acc_reg,   acc_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic [BIN_W-1:0]   bin_reg,   bin_next;
  logic               err_reg,   err_next;

  logic [DIGITS-1:0]  nib_bad;
  logic               word_bad;
  logic [3:0]         top_nib;
  logic [BIN_W-1:0]   acc_step;

  // One comparator per nibble; any digit above 9 poisons the whole word.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib_chk
      assign nib_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign word_bad = |nib_bad;
  assign top_nib  = shift_reg[IN_W-1 -: 4];

  // acc*10 as shift-add, truncated to BIN_W; BIN_W is sized so it never overflows.
  assign acc_step = (acc_reg << 3) + (acc_reg << 1) + BIN_W'(top_nib);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      bin_reg   <= bin_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    bin_next   = bin_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          shift_next = bcd_in;
          acc_next   = '0;
          cnt_next   = '0;
          if (word_bad) begin
            bin_next   = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = CONV;
          end
        end
      end

      CONV: begin
        acc_next   = acc_step;
        shift_next = shift_reg << 4;
        cnt_next   = cnt_reg + CNT_W'(1);
        // Result register only moves on the final digit, so partial sums never leak out.
        if (cnt_reg == LAST_CNT) begin
          bin_next   = acc_step;
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign bin_out   = bin_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       bcd_in;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  bin_out;
  logic              err;
  logic              out_valid;
  logic              out_ready;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_q[$];
  int out_q[$];

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Transaction monitor: records accept cycles and delivered results.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      acc_q.push_back(cyc);
      $display("[TB] cyc %0d accept bcd=%h", cyc, bcd_in);
    end
    if (rst_n && out_valid && out_ready) begin
      out_q.push_back(int'(bin_out));
      $display("[TB] cyc %0d result bin=%0d err=%0d", cyc, bin_out, err);
    end
  end

  // Drives one word and returns just after the accepting edge (ok=0 if never accepted).
  task automatic do_accept(input logic [15:0] w, output bit ok);
    @(negedge clk);
    bcd_in   = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; bcd_in = '0; out_ready = 1'b0;
    #12;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (bin_out !== 14'd0) begin tests_failed++; $display("FAIL reset_bin_out: got %0d expected 0", bin_out); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    bit ready_leak;
    out_ready = 1'b1;
    do_accept(16'h1234, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_accept: got no accept expected accept"); end
    n = 0; ready_leak = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) ready_leak = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (in_ready) ready_leak = 1'b1;
    tests_run++;
    if (n !== DIGITS) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", n, DIGITS); end
    tests_run++;
    if (ready_leak) begin tests_failed++; $display("FAIL basic_in_ready_busy: got 1 expected 0"); end
    tests_run++;
    if (bin_out !== 14'd1234) begin tests_failed++; $display("FAIL basic_bin_out: got %0d expected 1234", bin_out); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b expected 0", err); end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL basic_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_values();
    logic [15:0] vec_in  [4] = '{16'h9999, 16'h0000, 16'h0009, 16'h0090};
    int          vec_exp [4] = '{9999, 0, 9, 90};
    bit ok;
    int n;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_accept(vec_in[k], ok);
      n = 0;
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      tests_run++;
      if (!ok || n !== DIGITS) begin
        tests_failed++; $display("FAIL values_latency_%h: got %0d expected %0d", vec_in[k], n, DIGITS);
      end
      tests_run++;
      if (int'(bin_out) !== vec_exp[k] || err !== 1'b0) begin
        tests_failed++; $display("FAIL values_%h: got bin=%0d err=%b expected bin=%0d err=0", vec_in[k], bin_out, err, vec_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_error();
    bit ok;
    int n;
    out_ready = 1'b1;
    do_accept(16'h12A4, ok);
    // Invalid words skip CONV: result is already up in the cycle right after the accept edge.
    tests_run++;
    if (!ok || out_valid !== 1'b1) begin tests_failed++; $display("FAIL error_latency: got out_valid=%b expected 1", out_valid); end
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL error_flag: got %b expected 1", err); end
    tests_run++;
    if (bin_out !== 14'd0) begin tests_failed++; $display("FAIL error_bin_out: got %0d expected 0", bin_out); end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL error_in_ready: got %b expected 1", in_ready); end
    do_accept(16'h0042, ok);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== DIGITS || bin_out !== 14'd42 || err !== 1'b0) begin
      tests_failed++; $display("FAIL error_recover: got lat=%0d bin=%0d err=%b expected lat=4 bin=42 err=0", n, bin_out, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    int acc_cnt;
    bit held;
    out_ready = 1'b0;
    do_accept(16'h0500, ok);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (!ok || n !== DIGITS) begin tests_failed++; $display("FAIL bp_latency: got %0d expected %0d", n, DIGITS); end
    acc_cnt = acc_q.size();
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      bcd_in   = 16'h0123 + 16'(i);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || bin_out !== 14'h01F4 || err !== 1'b0 || in_ready !== 1'b0) held = 1'b0;
    end
    in_valid = 1'b0;
    tests_run++;
    if (!held) begin
      tests_failed++; $display("FAIL bp_hold: got out_valid=%b bin=%0d err=%b in_ready=%b expected 1/500/0/0", out_valid, bin_out, err, in_ready);
    end
    tests_run++;
    if (acc_q.size() !== acc_cnt) begin tests_failed++; $display("FAIL bp_no_accept: got %0d accepts expected %0d", acc_q.size(), acc_cnt); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 14'd500) begin
      tests_failed++; $display("FAIL bp_release: got out_valid=%b in_ready=%b bin=%0d expected 0/1/500", out_valid, in_ready, bin_out);
    end
    tests_run++;
    if (out_q.size() == 0 || out_q[$] !== 500) begin tests_failed++; $display("FAIL bp_transfer: expected one transfer of 500"); end
  endtask

  task automatic test_back_to_back();
    int i;
    acc_q.delete();
    out_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    bcd_in    = 16'h0001;
    in_valid  = 1'b1;
    i = 0;
    while (acc_q.size() < 1 && i < 40) begin @(negedge clk); i++; end
    bcd_in = 16'h0010;
    i = 0;
    while (acc_q.size() < 2 && i < 40) begin @(negedge clk); i++; end
    in_valid = 1'b0;
    i = 0;
    while (out_q.size() < 2 && i < 40) begin @(negedge clk); i++; end
    tests_run++;
    if (acc_q.size() !== 2 || out_q.size() !== 2) begin
      tests_failed++; $display("FAIL b2b_count: got %0d accepts %0d results expected 2/2", acc_q.size(), out_q.size());
    end else begin
      tests_run++;
      if (out_q[0] !== 1 || out_q[1] !== 10) begin
        tests_failed++; $display("FAIL b2b_values: got %0d,%0d expected 1,10", out_q[0], out_q[1]);
      end
      tests_run++;
      if (acc_q[1] - acc_q[0] !== DIGITS + 2) begin
        tests_failed++; $display("FAIL b2b_spacing: got %0d expected %0d", acc_q[1] - acc_q[0], DIGITS + 2);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    int out_cnt;
    out_ready = 1'b1;
    out_cnt = out_q.size();
    do_accept(16'h8765, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
      tests_failed++; $display("FAIL areset_outputs: got out_valid=%b bin=%0d err=%b expected 0/0/0", out_valid, bin_out, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_q.size() !== out_cnt) begin
      tests_failed++; $display("FAIL areset_idle: got in_ready=%b results=%0d expected 1/%0d", in_ready, out_q.size(), out_cnt);
    end
    do_accept(16'h8765, ok);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (!ok || n !== DIGITS || bin_out !== 14'h223D || err !== 1'b0) begin
      tests_failed++; $display("FAIL areset_fresh: got lat=%0d bin=%0d err=%b expected lat=4 bin=8765 err=0", n, bin_out, err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_error();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
